// File: rtl/l1_sched_pkg.sv
// l1_sched_pkg: width helpers and pointer arithmetic shared by the L1 buffer controllers.
package l1_sched_pkg;
    function automatic int vegeta_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
    function automatic int idx_width(input int depth);
        return vegeta_clog2(depth);
    endfunction
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction
    // Depth need not be a power of two, so wrap explicitly instead of relying on overflow.
    function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction
endpackage

// File: rtl/l1_buffer_scheduler_if.sv
// l1_buffer_scheduler_if: lane/row handshakes plus the buffer control pins driven by the scheduler.
interface l1_buffer_scheduler_if import l1_sched_pkg::*; #(
    parameter int LANE_COUNT = 4,
    parameter int DATA_DEPTH = 16
);
    localparam int IDXW = idx_width(DATA_DEPTH);
    logic [LANE_COUNT-1:0] lane_valid;
    logic [LANE_COUNT-1:0] lane_ready;
    logic [LANE_COUNT-1:0] lane_full;
    logic [LANE_COUNT-1:0] buf_write;
    logic row_valid;
    logic row_ready;
    logic empty;
    logic buf_enable;
    logic [LANE_COUNT-1:0][IDXW-1:0] buf_write_index;
    logic [IDXW-1:0] buf_read_index;
    modport master (
        output lane_valid, row_ready,
        input lane_ready, lane_full, row_valid, empty, buf_enable, buf_write, buf_write_index, buf_read_index
    );
    modport slave (
        input lane_valid, row_ready,
        output lane_ready, lane_full, row_valid, empty, buf_enable, buf_write, buf_write_index, buf_read_index
    );
endinterface

// File: rtl/lane_fill_tracker.sv
// lane_fill_tracker: write pointer and occupancy for one buffer column.
module lane_fill_tracker import l1_sched_pkg::*; #(
    parameter int DATA_DEPTH = 16,
    parameter int IDXW = idx_width(DATA_DEPTH),
    parameter int CNTW = cnt_width(DATA_DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            inc,
    input  logic            dec,
    output logic [IDXW-1:0] wp,
    output logic [CNTW-1:0] cnt
);
    logic [IDXW-1:0] wp_q, wp_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    always_comb begin
        wp_d  = flush ? '0 : inc ? IDXW'(wrap_inc(32'(wp_q), DATA_DEPTH)) : wp_q;
        cnt_d = flush ? '0 : cnt_q + CNTW'(inc) - CNTW'(dec);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            cnt_q <= cnt_d;
        end
    end
    assign wp  = wp_q;
    assign cnt = cnt_q;
endmodule

// File: rtl/l1_buffer_scheduler.sv
// l1_buffer_scheduler: runs an independent-write L1 buffer as a row-granular circular FIFO,
// arbitrating lane writes against row reads since the buffer drops a read on any same-cycle write.
module l1_buffer_scheduler import l1_sched_pkg::*; #(
    parameter int LANE_COUNT = 4,
    parameter int DATA_DEPTH = 16
) (
    input logic clk,
    input logic rst_n,
    input logic flush,
    l1_buffer_scheduler_if.slave bus
);
    localparam int IDXW = idx_width(DATA_DEPTH);
    localparam int CNTW = cnt_width(DATA_DEPTH);
    logic [LANE_COUNT-1:0][IDXW-1:0] wp;
    logic [LANE_COUNT-1:0][CNTW-1:0] cnt;
    logic [LANE_COUNT-1:0] write_req, nonzero, full;
    logic [IDXW-1:0] rp_q, rp_d;
    logic row_valid_q, row_valid_d, read_prio_q, read_prio_d;
    logic read_elig, do_read, wr_ok;
    for (genvar l = 0; l < LANE_COUNT; l++) begin : g_lane
        lane_fill_tracker #(.DATA_DEPTH(DATA_DEPTH), .IDXW(IDXW), .CNTW(CNTW)) u_trk (
            .clk   (clk),
            .rst_n (rst_n),
            .flush (flush),
            .inc   (bus.buf_write[l]),
            .dec   (do_read),
            .wp    (wp[l]),
            .cnt   (cnt[l])
        );
        assign nonzero[l]   = cnt[l] != '0;
        assign full[l]      = cnt[l] == CNTW'(DATA_DEPTH);
        assign write_req[l] = bus.lane_valid[l] && !full[l];
    end
    // read_prio remembers a read that lost to writers, so it wins the very next cycle.
    always_comb begin
        read_elig   = (&nonzero) && (!row_valid_q || bus.row_ready);
        do_read     = !flush && read_elig && (read_prio_q || write_req == '0);
        wr_ok       = rst_n && !flush && !do_read;
        rp_d        = flush ? '0 : do_read ? IDXW'(wrap_inc(32'(rp_q), DATA_DEPTH)) : rp_q;
        row_valid_d = !flush && (do_read || (row_valid_q && !bus.row_ready));
        read_prio_d = !flush && !do_read && (read_prio_q || (read_elig && write_req != '0));
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rp_q        <= '0;
            row_valid_q <= 1'b0;
            read_prio_q <= 1'b0;
        end else begin
            rp_q        <= rp_d;
            row_valid_q <= row_valid_d;
            read_prio_q <= read_prio_d;
        end
    end
    assign bus.lane_ready      = write_req & {LANE_COUNT{wr_ok}};
    assign bus.buf_write       = bus.lane_valid & bus.lane_ready;
    assign bus.buf_enable      = do_read || (bus.buf_write != '0);
    assign bus.buf_write_index = wp;
    assign bus.buf_read_index  = rp_q;
    assign bus.row_valid       = row_valid_q;
    assign bus.lane_full       = full;
    assign bus.empty           = !(&nonzero);
endmodule

// File: tb/tb_l1_buffer_scheduler.sv
// tb_l1_buffer_scheduler: directed scenarios plus random traffic against a queue-based FIFO model
// and a behavioural buffer array written/read through the DUT's own index outputs.
module tb_l1_buffer_scheduler;
    localparam int L = 4;
    localparam int D = 5;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;
    l1_buffer_scheduler_if #(.LANE_COUNT(L), .DATA_DEPTH(D)) bus ();
    l1_buffer_scheduler #(.LANE_COUNT(L), .DATA_DEPTH(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );
    int checks = 0;
    int errors = 0;
    int q[L][$];
    int wtot[L];
    int rtot;
    bit m_rv, m_prio;
    int mem[D][L];
    int tok = 0;
    int nreads;
    int ridx_log[$];
    int widx0_log[$];
    int obs_bw, obs_rv, obs_ri, obs_empty, obs_lr, obs_full;
    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask
    function automatic void model_clear();
        for (int l = 0; l < L; l++) begin
            q[l].delete();
            wtot[l] = 0;
        end
        rtot   = 0;
        m_rv   = 1'b0;
        m_prio = 1'b0;
    endfunction
    task automatic step(input logic [L-1:0] lv, input logic rr, input logic fl);
        bit elig, rd, ne;
        logic [L-1:0] req, exr, exw;
        int ri, wi;
        @(negedge clk);
        bus.lane_valid = lv;
        bus.row_ready  = rr;
        flush          = fl;
        #1;
        ne = 1'b1;
        for (int l = 0; l < L; l++) begin
            if (q[l].size() == 0) ne = 1'b0;
            req[l] = lv[l] && q[l].size() < D;
        end
        elig = ne && (!m_rv || rr);
        rd   = !fl && elig && (m_prio || req == '0);
        exr  = (fl || rd) ? '0 : req;
        exw  = lv & exr;
        obs_bw = int'(bus.buf_write); obs_rv = int'(bus.row_valid); obs_ri = int'(bus.buf_read_index);
        obs_empty = int'(bus.empty); obs_lr = int'(bus.lane_ready); obs_full = int'(bus.lane_full);
        check("lane_ready", obs_lr, int'(exr));
        check("buf_write", obs_bw, int'(exw));
        check("buf_enable", int'(bus.buf_enable), int'(rd || exw != '0));
        check("row_valid", obs_rv, int'(m_rv));
        check("empty", obs_empty, int'(!ne));
        check("buf_read_index", obs_ri, rtot % D);
        for (int l = 0; l < L; l++) begin
            check("lane_full", int'(bus.lane_full[l]), int'(q[l].size() == D));
            check("buf_write_index", int'(bus.buf_write_index[l]), wtot[l] % D);
        end
        ri = obs_ri;
        if (rd)
            for (int l = 0; l < L; l++) check("row_data", (ri < D) ? mem[ri][l] : -1, q[l][0]);
        if (bus.buf_enable && bus.buf_write == '0) begin
            nreads++;
            ridx_log.push_back(ri);
        end
        if (bus.buf_write[0]) widx0_log.push_back(int'(bus.buf_write_index[0]));
        for (int l = 0; l < L; l++)
            if (exw[l]) begin
                tok++;
                wi = int'(bus.buf_write_index[l]);
                if (wi < D && bus.buf_write[l]) mem[wi][l] = tok;
                q[l].push_back(tok);
                wtot[l]++;
            end
        @(posedge clk);
        if (fl) model_clear();
        else begin
            if (rd) begin
                for (int l = 0; l < L; l++) void'(q[l].pop_front());
                rtot++;
            end
            m_prio = !rd && (m_prio || (elig && req != '0));
            m_rv   = rd || (m_rv && !rr);
        end
    endtask
    task automatic reset_mid();
        @(negedge clk);
        bus.lane_valid = '0;
        flush = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_empty", int'(bus.empty), 1);
        check("rst_lane_ready", int'(bus.lane_ready), 0);
        check("rst_row_valid", int'(bus.row_valid), 0);
        check("rst_buf_enable", int'(bus.buf_enable), 0);
        check("rst_read_index", int'(bus.buf_read_index), 0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask
    initial begin
        int max_low, low_run, ri0, rv_hi;
        bus.lane_valid = '0;
        bus.row_ready  = 1'b0;
        model_clear();
        #1;
        check("por_empty", int'(bus.empty), 1);
        check("por_lane_full", int'(bus.lane_full), 0);
        check("por_buf_write", int'(bus.buf_write), 0);
        check("por_write_index", int'(bus.buf_write_index), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(4'b0111, 1'b0, 1'b0);
        step(4'b0111, 1'b0, 1'b0);
        step(4'b0101, 1'b0, 1'b0);
        step(4'b1000, 1'b0, 1'b0);
        reset_mid();
        step('0, 1'b0, 1'b0);
        check("idle_buf_enable", obs_bw, 0);
        nreads = 0;
        ridx_log.delete();
        step(4'b0001, 1'b0, 1'b0);
        step(4'b0001, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b0);
        repeat (4) step('0, 1'b0, 1'b0);
        check("skew_reads", nreads, 1);
        check("skew_read_index", (ridx_log.size() > 0) ? ridx_log[0] : -1, 0);
        check("skew_row_valid", obs_rv, 1);
        check("skew_empty", obs_empty, 1);
        step(4'b1111, 1'b1, 1'b0);
        step(4'b1111, 1'b1, 1'b0);
        nreads = 0;
        max_low = 0;
        low_run = 0;
        repeat (10) begin
            step(4'b1111, 1'b1, 1'b0);
            low_run = obs_lr[0] ? 0 : low_run + 1;
            if (low_run > max_low) max_low = low_run;
        end
        check("fair_reads", nreads, 5);
        check("fair_max_low_run", max_low, 1);
        step(4'b1111, 1'b1, 1'b1);
        step('0, 1'b0, 1'b0);
        repeat (6) step(4'b1111, 1'b0, 1'b0);
        nreads = 0;
        step('0, 1'b0, 1'b0);
        ri0 = obs_ri;
        repeat (3) begin
            step('0, 1'b0, 1'b0);
            check("bp_read_index", obs_ri, ri0);
        end
        check("bp_no_read", nreads, 0);
        rv_hi = 0;
        repeat (3) begin
            step('0, 1'b1, 1'b0);
            rv_hi += obs_rv;
        end
        check("bp_reads", nreads, 3);
        check("bp_row_valid_run", rv_hi, 3);
        step(4'b1111, 1'b1, 1'b1);
        check("flush_buf_write", obs_bw, 0);
        step('0, 1'b0, 1'b0);
        check("flush_row_valid", obs_rv, 0);
        check("flush_read_index", obs_ri, 0);
        check("flush_empty", obs_empty, 1);
        repeat (5) step(4'b0100, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 1'b0);
        check("full_lane_ready2", (obs_lr >> 2) & 1, 0);
        check("full_lane_full2", (obs_full >> 2) & 1, 1);
        ridx_log.delete();
        widx0_log.delete();
        for (int i = 0; i < 60 && ridx_log.size() < 7; i++) step(4'b1111, 1'b1, 1'b0);
        check("wrap_read_count", int'(ridx_log.size() >= 7), 1);
        for (int i = 0; i < 7 && i < ridx_log.size(); i++) check("wrap_read_index", ridx_log[i], i % D);
        for (int i = 0; i < 7 && i < widx0_log.size(); i++) check("wrap_write_index0", widx0_log[i], i % D);
        repeat (1500) step(4'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 49) == 0));
        reset_mid();
        repeat (200) step(4'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
